// File: rtl/switch_box_config_loader.sv
// ---------------------------------------------------------------------------
// switch_box_config_loader
//
// Collects a switch box configuration frame from a stream of words delivered
// over a valid/ready handshake. Words are assembled in a shadow register, LSB
// word first. The complete frame is copied into config_out in a single cycle,
// so the switch box never sees a partially written frame.
//
// Optional feature (macro SWITCHBOX_CONFIG_CHECKSUM_EN):
//   Each frame carries one extra word, the XOR of the raw data words. The
//   frame is committed only when that word matches. A mismatch sets the
//   sticky error flag and discards the frame. Without the macro there is no
//   checksum word and error is always 0.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous reset, active-high
//   start        in   begin a frame load (honoured only when idle)
//   abort        in   cancel an in-progress load
//   word_valid   in   word_data is valid
//   word_ready   out  loader accepts a word this cycle (state is LOAD)
//   word_data    in   configuration word, LSB word first
//   busy         out  loader is not idle
//   done         out  one-cycle pulse when a new frame is committed
//   error        out  sticky checksum failure flag
//   config_valid out  config_out holds a committed frame
//   config_out   out  active configuration to the switch box
// ---------------------------------------------------------------------------
module switch_box_config_loader #(
  parameter int CONFIG_WIDTH = 112,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    word_valid,
  output logic                    word_ready,
  input  logic [WORD_WIDTH-1:0]   word_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    config_valid,
  output logic [CONFIG_WIDTH-1:0] config_out
);

  localparam int NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  // Index of the final word of a frame: the checksum word follows the data
  // words when the feature is enabled.
`ifdef SWITCHBOX_CONFIG_CHECKSUM_EN
  localparam int LAST_IDX = NUM_WORDS;
`else
  localparam int LAST_IDX = NUM_WORDS - 1;
`endif
  localparam int CNT_W = $clog2(NUM_WORDS + 1);

`ifdef SWITCHBOX_CONFIG_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd3
  } state_t;
`endif

  state_t                  state;
  state_t                  next_state;
  logic [CNT_W-1:0]        word_cnt;
  logic [CONFIG_WIDTH-1:0] shadow;
  logic [CONFIG_WIDTH-1:0] word_mask;
  logic [CONFIG_WIDTH-1:0] word_spread;
  logic                    handshake;
  logic                    last_word;
  logic                    data_word;
  logic                    start_ok;

`ifdef SWITCHBOX_CONFIG_CHECKSUM_EN
  logic [WORD_WIDTH-1:0]   csum_acc;
  logic [WORD_WIDTH-1:0]   csum_word;
  logic                    csum_match;
  assign csum_match = (csum_acc == csum_word);
`endif

  assign word_ready = (state == LOAD);
  assign busy       = (state != IDLE);
  assign handshake  = word_valid & word_ready;
  assign last_word  = (word_cnt == CNT_W'(LAST_IDX));
  assign data_word  = (word_cnt < CNT_W'(NUM_WORDS));
  // abort also suppresses a coincident start.
  assign start_ok   = start & ~abort;

  // Word k lands on shadow bits [k*WORD_WIDTH +: WORD_WIDTH]. Building the
  // write as a bit mask keeps the partial last word in range: bits of that
  // word above CONFIG_WIDTH-1 simply have no destination.
  always_comb begin
    word_mask   = '0;
    word_spread = '0;
    for (int i = 0; i < CONFIG_WIDTH; i++) begin
      word_spread[i] = word_data[i % WORD_WIDTH];
      word_mask[i]   = ((i / WORD_WIDTH) == int'(word_cnt));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          next_state = IDLE;
        end else if (handshake && last_word) begin
`ifdef SWITCHBOX_CONFIG_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = COMMIT;
`endif
        end
      end
`ifdef SWITCHBOX_CONFIG_CHECKSUM_EN
      CHECK: begin
        if (abort || !csum_match) begin
          next_state = IDLE;
        end else begin
          next_state = COMMIT;
        end
      end
`endif
      // abort is ignored here: a commit always completes.
      COMMIT: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_cnt     <= '0;
      shadow       <= '0;
      config_out   <= '0;
      config_valid <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
`ifdef SWITCHBOX_CONFIG_CHECKSUM_EN
      csum_acc     <= '0;
      csum_word    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          word_cnt <= '0;
          shadow   <= '0;
`ifdef SWITCHBOX_CONFIG_CHECKSUM_EN
          csum_acc <= '0;
`endif
          // error is sticky until a start is actually honoured.
          if (start_ok) begin
            error <= 1'b0;
          end
        end
        LOAD: begin
          // A word arriving with abort is consumed but dropped.
          if (handshake && !abort) begin
            word_cnt <= word_cnt + CNT_W'(1);
            if (data_word) begin
              shadow <= (shadow & ~word_mask) | (word_spread & word_mask);
`ifdef SWITCHBOX_CONFIG_CHECKSUM_EN
              csum_acc <= csum_acc ^ word_data;
            end else begin
              csum_word <= word_data;
`endif
            end
          end
        end
`ifdef SWITCHBOX_CONFIG_CHECKSUM_EN
        CHECK: begin
          if (!abort && !csum_match) begin
            error <= 1'b1;
          end
        end
`endif
        COMMIT: begin
          config_out   <= shadow;
          config_valid <= 1'b1;
          done         <= 1'b1;
        end
        default: begin
          word_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_box_config_loader.sv
// ---------------------------------------------------------------------------
// tb_switch_box_config_loader
//
// Self-checking bench for switch_box_config_loader. Frames come from a table
// of {words, idle gap, expected config} records. Each expected frame is queued
// when its last word is driven and compared when done pulses. Hand-written
// sequences cover abort, abort-with-start in idle, reset mid-load and, with
// SWITCHBOX_CONFIG_CHECKSUM_EN, a bad checksum.
// ---------------------------------------------------------------------------
module tb_switch_box_config_loader;

  logic         clock;
  logic         reset;
  logic         start;
  logic         abort;
  logic         word_valid;
  logic         word_ready;
  logic [31:0]  word_data;
  logic         busy;
  logic         done;
  logic         error;
  logic         config_valid;
  logic [111:0] config_out;

  int checks = 0;
  int errors = 0;
  logic [111:0] sb_q[$];
  logic [111:0] last_cfg;

  typedef struct {
    logic [3:0][31:0] words;
    int               gap;
    logic [111:0]     expect_cfg;
  } frame_vec_t;

  frame_vec_t vecs[4];

  switch_box_config_loader dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word_data    (word_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .config_valid (config_valid),
    .config_out   (config_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Overall time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive inputs just after the rising edge.
  task automatic applyStimulus(input logic st, input logic ab, input logic vld,
                               input logic [31:0] data);
    @(posedge clock);
    #1;
    start      = st;
    abort      = ab;
    word_valid = vld;
    word_data  = data;
  endtask

  // Wait (bounded) until word_ready is seen; the handshake then completes at
  // the next rising edge.
  task automatic waitReady();
    int n = 0;
    @(negedge clock);
    while (!word_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("ready_timeout", {127'd0, word_ready}, 128'd1);
  endtask

  task automatic sendWord(input logic [31:0] data);
    applyStimulus(1'b0, 1'b0, 1'b1, data);
    waitReady();
  endtask

  // Scoreboard: every done pulse must match the oldest queued frame.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1, expected done=0");
      end else begin
        logic [111:0] exp_cfg;
        exp_cfg = sb_q.pop_front();
        checkOutput("config_out", {16'd0, config_out}, {16'd0, exp_cfg});
        checkOutput("config_valid", {127'd0, config_valid}, 128'd1);
      end
    end
  end

  task automatic runFrame(input frame_vec_t v);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        // Idle gaps: start is held high to show it is ignored while busy.
        for (int g = 0; g < v.gap; g++) begin
          applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
          @(negedge clock);
          checkOutput("gap_ready", {127'd0, word_ready}, 128'd1);
          checkOutput("gap_busy", {127'd0, busy}, 128'd1);
        end
      end
      if (k == 3) begin
        sb_q.push_back(v.expect_cfg);
      end
      sendWord(v.words[k]);
    end
`ifdef SWITCHBOX_CONFIG_CHECKSUM_EN
    sendWord(v.words[0] ^ v.words[1] ^ v.words[2] ^ v.words[3]);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clock);
    checkOutput("done_in_check", {127'd0, done}, 128'd0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clock);
    checkOutput("done_early", {127'd0, done}, 128'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clock);
    checkOutput("done_pulse", {127'd0, done}, 128'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clock);
    checkOutput("done_clear", {127'd0, done}, 128'd0);
    checkOutput("busy_after", {127'd0, busy}, 128'd0);
    checkOutput("error_clear", {127'd0, error}, 128'd0);
    last_cfg = v.expect_cfg;
  endtask

  initial begin
    vecs[0].words = {32'h0000ABCD, 32'h33333333, 32'h22222222, 32'h11111111};
    vecs[0].gap   = 0;
    vecs[0].expect_cfg = 112'h0000ABCD_33333333_22222222_11111111;
    vecs[1].words = {32'hFFFF1234, 32'h33333333, 32'h22222222, 32'h11111111};
    vecs[1].gap   = 0;
    vecs[1].expect_cfg = 112'h1234_33333333_22222222_11111111;
    vecs[2].words = {32'h0000ABCD, 32'h33333333, 32'h22222222, 32'h11111111};
    vecs[2].gap   = 3;
    vecs[2].expect_cfg = 112'h0000ABCD_33333333_22222222_11111111;
    vecs[3].words = {32'h55AA5AA5, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF};
    vecs[3].gap   = 1;
    vecs[3].expect_cfg = 112'h5AA5_89ABCDEF_01234567_DEADBEEF;

    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    word_valid = 1'b0;
    word_data  = 32'd0;
    last_cfg   = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_word_ready", {127'd0, word_ready}, 128'd0);
    checkOutput("rst_busy", {127'd0, busy}, 128'd0);
    checkOutput("rst_done", {127'd0, done}, 128'd0);
    checkOutput("rst_error", {127'd0, error}, 128'd0);
    checkOutput("rst_config_valid", {127'd0, config_valid}, 128'd0);
    checkOutput("rst_config_out", {16'd0, config_out}, 128'd0);
    reset = 1'b0;

    $display("[TB] table-driven frames");
    for (int i = 0; i < 4; i++) begin
      runFrame(vecs[i]);
    end

    // Abort after two words; the third word arrives together with abort.
    $display("[TB] abort sequence");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    sendWord(32'hAAAA0001);
    sendWord(32'hAAAA0002);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hAAAA0003);
    @(negedge clock);
    checkOutput("abort_busy_same", {127'd0, busy}, 128'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clock);
    checkOutput("abort_busy", {127'd0, busy}, 128'd0);
    checkOutput("abort_ready", {127'd0, word_ready}, 128'd0);
    checkOutput("abort_cfg", {16'd0, config_out}, {16'd0, last_cfg});
    checkOutput("abort_cfg_valid", {127'd0, config_valid}, 128'd1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clock);
    checkOutput("abort_no_done", {127'd0, done}, 128'd0);

    // abort in idle suppresses a coincident start.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clock);
    checkOutput("abort_start_busy", {127'd0, busy}, 128'd0);

    // Reset in the cycle after word 2 is accepted.
    $display("[TB] reset mid-load");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    sendWord(32'hBBBB0000);
    sendWord(32'hBBBB0001);
    sendWord(32'hBBBB0002);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("mid_rst_busy", {127'd0, busy}, 128'd0);
    checkOutput("mid_rst_ready", {127'd0, word_ready}, 128'd0);
    checkOutput("mid_rst_cfg", {16'd0, config_out}, 128'd0);
    checkOutput("mid_rst_cfg_valid", {127'd0, config_valid}, 128'd0);
    checkOutput("mid_rst_done", {127'd0, done}, 128'd0);
    runFrame(vecs[0]);

`ifdef SWITCHBOX_CONFIG_CHECKSUM_EN
    $display("[TB] bad checksum");
    runFrame(vecs[3]);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      sendWord(vecs[0].words[k]);
    end
    sendWord(32'h00000000);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clock);
    checkOutput("csum_error", {127'd0, error}, 128'd1);
    checkOutput("csum_busy", {127'd0, busy}, 128'd0);
    checkOutput("csum_no_done", {127'd0, done}, 128'd0);
    checkOutput("csum_cfg", {16'd0, config_out}, {16'd0, last_cfg});
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clock);
    checkOutput("csum_error_sticky", {127'd0, error}, 128'd1);
    runFrame(vecs[0]);
`endif

    checkOutput("sb_empty", 128'(sb_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
